// File: rtl/const_div_serial.sv
// const_div_serial: digit-serial unsigned divider by a compile-time constant.
// Consumes CHUNK dividend bits per clock, most significant digit first, and
// returns floor(in_data/DIVISOR) and in_data mod DIVISOR.
// Optional feature macro: CONST_DIV_FWD_EN lets a new dividend be accepted
// in the same cycle the finished result is taken, skipping the IDLE cycle.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready
// are both high. valid never depends on ready. The payload is sampled only on
// that edge and is held stable by the sender while valid is high.
module const_div_serial #(
    parameter  int WIDTH   = 16,
    parameter  int DIVISOR = 11,
    parameter  int CHUNK   = 4,
    localparam int RW      = $clog2(DIVISOR),
    localparam int STEPS   = WIDTH / CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_quot,
    output logic [RW-1:0]    out_rem
);

    // Partial dividend t = r*2^CHUNK + c needs RW+CHUNK bits.
    localparam int TW = RW + CHUNK;
    localparam int CW = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [TW-1:0] DIV_T = TW'(DIVISOR);

    // Parameter sanity: a bad configuration stops elaboration.
    if (CHUNK < 1 || CHUNK > 8) begin : g_bad_chunk
        $fatal(1, "const_div_serial: CHUNK must be in 1..8");
    end
    if (WIDTH % CHUNK != 0) begin : g_bad_width
        $fatal(1, "const_div_serial: WIDTH must be a multiple of CHUNK");
    end
    if (DIVISOR < 2 || (WIDTH < 63 && longint'(DIVISOR) >= (longint'(1) << WIDTH))) begin : g_bad_div
        $fatal(1, "const_div_serial: DIVISOR must satisfy 2 <= DIVISOR < 2^WIDTH");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              load;
    logic [WIDTH-1:0]  shift_q;
    logic [WIDTH-1:0]  quot_q;
    logic [RW-1:0]     rem_q;
    logic [CW-1:0]     cnt_q;
    logic [CHUNK-1:0]  c_digit;
    logic [TW-1:0]     t_part;
    logic [CHUNK-1:0]  q_digit;
    logic [RW-1:0]     r_nxt;

    // Quotient digit and remainder of the current step. The divisor is a
    // constant, so this reduces to a fixed lookup on t. Since r < DIVISOR,
    // the digit always fits in CHUNK bits.
    always_comb begin
        c_digit = shift_q[WIDTH-1 -: CHUNK];
        t_part  = {rem_q, c_digit};
        q_digit = CHUNK'(t_part / DIV_T);
        r_nxt   = RW'(t_part % DIV_T);
    end

    // Next-state and handshake decode; in_ready is forced low during reset.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        load      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load      = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == CW'(STEPS - 1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
`ifdef CONST_DIV_FWD_EN
                    in_ready = 1'b1;
                    if (in_valid) begin
                        load      = 1'b1;
                        state_nxt = BUSY;
                    end else begin
                        state_nxt = IDLE;
                    end
`else
                    state_nxt = IDLE;
`endif
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (rst) begin
            in_ready = 1'b0;
            load     = 1'b0;
        end
    end

    // State register and datapath: load on accept, one digit per BUSY cycle,
    // everything frozen in DONE until the result is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            shift_q <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                shift_q <= in_data;
                rem_q   <= '0;
                cnt_q   <= '0;
            end else if (state == BUSY) begin
                shift_q <= shift_q << CHUNK;
                quot_q  <= (quot_q << CHUNK) | WIDTH'(q_digit);
                rem_q   <= r_nxt;
                cnt_q   <= cnt_q + 1'b1;
            end
        end
    end

    // Result is presented straight from the registers.
    always_comb begin
        out_valid = (state == DONE);
        out_quot  = quot_q;
        out_rem   = rem_q;
    end

endmodule

// File: tb/tb_const_div_serial.sv
// Bench for const_div_serial: a default 16/11/4 instance (directed plus
// random traffic) and a 24/7/3 instance (random sweep), each scored against
// plain integer division by a per-cycle monitor.
module tb_const_div_serial;

`ifdef CONST_DIV_FWD_EN
    localparam int B2B_GAP = 5;
`else
    localparam int B2B_GAP = 6;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT A: 16 / 11 / 4 ----------------
    logic        a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b0;
    logic [15:0] a_in_data = '0, a_out_quot;
    logic [3:0]  a_out_rem;

    const_div_serial #(.WIDTH(16), .DIVISOR(11), .CHUNK(4)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_quot(a_out_quot), .out_rem(a_out_rem)
    );

    // ---------------- DUT B: 24 / 7 / 3 ----------------
    logic        b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b0;
    logic [23:0] b_in_data = '0, b_out_quot;
    logic [2:0]  b_out_rem;

    const_div_serial #(.WIDTH(24), .DIVISOR(7), .CHUNK(3)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_quot(b_out_quot), .out_rem(b_out_rem)
    );

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;

    task automatic chk(input bit ok, input string name, input longint act, input longint exp);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    logic [19:0] expa_q[$];   // {quot, rem} for A
    int          acca_q[$];   // edge number of each accept for A
    int          risea_q[$];  // cycle at which each A result first appears
    bit          pres_a = 1'b0;
    logic [26:0] expb_q[$];
    int          accb_q[$];
    bit          pres_b = 1'b0;

    // Monitor: model accepts with integer division, check every presented result.
    always @(negedge clk) begin
        if (rst) begin
            chk(a_in_ready == 1'b0, "a_in_ready_during_rst", a_in_ready, 0);
            chk(b_in_ready == 1'b0, "b_in_ready_during_rst", b_in_ready, 0);
            expa_q.delete(); acca_q.delete(); pres_a = 1'b0;
            expb_q.delete(); accb_q.delete(); pres_b = 1'b0;
        end else begin
            if (a_out_valid) begin
                if (expa_q.size() == 0) begin
                    chk(1'b0, "a_spurious_valid", a_out_valid, 0);
                end else begin
                    if (!pres_a) begin
                        chk(cyc == acca_q[0] + 4, "a_latency", cyc - acca_q[0], 4);
                        risea_q.push_back(cyc);
                    end
                    chk(a_out_quot == expa_q[0][19:4], "a_quot", a_out_quot, expa_q[0][19:4]);
                    chk(a_out_rem == expa_q[0][3:0], "a_rem", a_out_rem, expa_q[0][3:0]);
`ifdef CONST_DIV_FWD_EN
                    chk(a_in_ready == a_out_ready, "a_in_ready_done", a_in_ready, a_out_ready);
`else
                    chk(a_in_ready == 1'b0, "a_in_ready_done", a_in_ready, 0);
`endif
                    if (a_out_ready) begin
                        void'(expa_q.pop_front()); void'(acca_q.pop_front()); pres_a = 1'b0;
                    end else begin
                        pres_a = 1'b1;
                    end
                end
            end
            if (a_in_valid && a_in_ready) begin
                expa_q.push_back({16'(a_in_data / 11), 4'(a_in_data % 11)});
                acca_q.push_back(cyc + 1);
            end

            if (b_out_valid) begin
                if (expb_q.size() == 0) begin
                    chk(1'b0, "b_spurious_valid", b_out_valid, 0);
                end else begin
                    if (!pres_b) chk(cyc == accb_q[0] + 8, "b_latency", cyc - accb_q[0], 8);
                    chk(b_out_quot == expb_q[0][26:3], "b_quot", b_out_quot, expb_q[0][26:3]);
                    chk(b_out_rem == expb_q[0][2:0], "b_rem", b_out_rem, expb_q[0][2:0]);
                    if (b_out_ready) begin
                        void'(expb_q.pop_front()); void'(accb_q.pop_front()); pres_b = 1'b0;
                    end else begin
                        pres_b = 1'b1;
                    end
                end
            end
            if (b_in_valid && b_in_ready) begin
                expb_q.push_back({24'(b_in_data / 7), 3'(b_in_data % 7)});
                accb_q.push_back(cyc + 1);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic a_send(input logic [15:0] d);
        int n = 0;
        @(posedge clk); #1;
        a_in_valid = 1'b1; a_in_data = d;
        do begin @(negedge clk); n++; end while (!a_in_ready && n < 100);
        chk(a_in_ready == 1'b1, "a_accept_timeout", a_in_ready, 1);
        @(posedge clk); #1;
        a_in_valid = 1'b0; a_in_data = 16'($urandom);
    endtask

    task automatic a_wait_out(output logic [15:0] q, output logic [3:0] r);
        int n = 0;
        @(negedge clk);
        while (!a_out_valid && n < 100) begin @(negedge clk); n++; end
        chk(a_out_valid == 1'b1, "a_result_timeout", a_out_valid, 1);
        q = a_out_quot; r = a_out_rem;
    endtask

    task automatic a_recv_rand();
        int n = 0;
        bit done = 1'b0;
        while (!done && n < 200) begin
            @(posedge clk); #1;
            a_out_ready = 1'($urandom_range(0, 1));
            @(negedge clk); n++;
            if (a_out_valid && a_out_ready) done = 1'b1;
        end
        chk(done, "a_recv_timeout", done, 1);
    endtask

    task automatic b_send(input logic [23:0] d);
        int n = 0;
        repeat ($urandom_range(0, 1)) @(posedge clk);
        @(posedge clk); #1;
        b_in_valid = 1'b1; b_in_data = d;
        do begin @(negedge clk); n++; end while (!b_in_ready && n < 100);
        chk(b_in_ready == 1'b1, "b_accept_timeout", b_in_ready, 1);
        @(posedge clk); #1;
        b_in_valid = 1'b0; b_in_data = 24'($urandom);
    endtask

    task automatic b_recv(output logic [23:0] q, output logic [2:0] r);
        int n = 0;
        bit done = 1'b0;
        q = '0; r = '0;
        while (!done && n < 200) begin
            @(posedge clk); #1;
            b_out_ready = 1'($urandom_range(0, 1));
            @(negedge clk); n++;
            if (b_out_valid && b_out_ready) begin
                done = 1'b1; q = b_out_quot; r = b_out_rem;
            end
        end
        chk(done, "b_recv_timeout", done, 1);
    endtask

    // ---------------- stimulus ----------------
    int          dir_in[6] = '{1234, 65535, 0, 10, 11, 22};
    int          dir_q[6]  = '{112, 5957, 0, 0, 1, 2};
    int          dir_r[6]  = '{2, 8, 0, 10, 0, 0};
    int          b2b_in[3] = '{100, 200, 300};
    int          bd_in[4]  = '{0, 16777215, 6, 7};
    int          bd_q[4]   = '{0, 2396745, 0, 1};
    int          bd_r[4]   = '{0, 0, 6, 0};

    initial begin
        logic [15:0] q;
        logic [3:0]  r;
        logic [15:0] hq;
        logic [3:0]  hr;
        logic [23:0] bq;
        logic [2:0]  br;
        int idx, n;
        bit acc;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk(a_out_valid == 1'b0, "reset_out_valid", a_out_valid, 0);
        chk(a_out_quot == 16'd0, "reset_out_quot", a_out_quot, 0);
        chk(a_out_rem == 4'd0, "reset_out_rem", a_out_rem, 0);
        chk(a_in_ready == 1'b1, "reset_in_ready", a_in_ready, 1);
        chk(b_out_valid == 1'b0, "reset_b_out_valid", b_out_valid, 0);

        // Known results and boundaries around the divisor.
        a_out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            a_send(16'(dir_in[i]));
            a_wait_out(q, r);
            chk(q == 16'(dir_q[i]), "dir_quot", q, dir_q[i]);
            chk(r == 4'(dir_r[i]), "dir_rem", r, dir_r[i]);
        end
        @(posedge clk); #1;

        // Backpressure: result frozen while out_ready is low.
        a_out_ready = 1'b0;
        a_send(16'd777);
        a_wait_out(hq, hr);
        chk(hq == 16'd70 && hr == 4'd7, "hold_value", {hq, hr}, {16'd70, 4'd7});
        repeat (6) begin
            @(negedge clk);
            chk(a_out_valid == 1'b1, "hold_valid", a_out_valid, 1);
            chk(a_out_quot == hq, "hold_quot", a_out_quot, hq);
            chk(a_out_rem == hr, "hold_rem", a_out_rem, hr);
            chk(a_in_ready == 1'b0, "hold_in_ready", a_in_ready, 0);
        end
        @(posedge clk); #1 a_out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        chk(a_out_valid == 1'b0, "release_out_valid", a_out_valid, 0);
        chk(a_in_ready == 1'b1, "release_idle", a_in_ready, 1);

        // Reset during the second BUSY step discards the division.
        a_send(16'd500);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        repeat (10) begin
            @(negedge clk);
            chk(a_out_valid == 1'b0, "discard_no_valid", a_out_valid, 0);
        end
        a_send(16'd500);
        a_wait_out(q, r);
        chk(q == 16'd45 && r == 4'd5, "after_reset_500", {q, r}, {16'd45, 4'd5});
        @(posedge clk); #1;

        // Back-to-back with in_valid and out_ready held high.
        risea_q.delete();
        idx = 0; n = 0;
        a_in_valid = 1'b1; a_in_data = 16'(b2b_in[0]);
        while (idx < 3 && n < 100) begin
            @(negedge clk); n++;
            acc = a_in_ready;
            @(posedge clk); #1;
            if (acc) begin
                idx++;
                if (idx < 3) a_in_data = 16'(b2b_in[idx]);
            end
        end
        a_in_valid = 1'b0;
        n = 0;
        while (risea_q.size() < 3 && n < 100) begin @(negedge clk); n++; end
        chk(risea_q.size() == 3, "b2b_count", risea_q.size(), 3);
        if (risea_q.size() == 3) begin
            chk(risea_q[1] - risea_q[0] == B2B_GAP, "b2b_gap1", risea_q[1] - risea_q[0], B2B_GAP);
            chk(risea_q[2] - risea_q[1] == B2B_GAP, "b2b_gap2", risea_q[2] - risea_q[1], B2B_GAP);
        end
        repeat (3) @(posedge clk);
        #1;

        // Random traffic on A with random consumer stalls.
        for (int i = 0; i < 200; i++) begin
            a_send(16'($urandom));
            a_recv_rand();
        end

        // B: boundaries, then random sweep.
        for (int i = 0; i < 4; i++) begin
            b_send(24'(bd_in[i]));
            b_recv(bq, br);
            chk(bq == 24'(bd_q[i]), "b_dir_quot", bq, bd_q[i]);
            chk(br == 3'(bd_r[i]), "b_dir_rem", br, bd_r[i]);
        end
        for (int i = 0; i < 2000; i++) begin
            b_send(24'($urandom));
            b_recv(bq, br);
        end
        repeat (4) @(negedge clk);
        chk(expa_q.size() == 0, "a_queue_drained", expa_q.size(), 0);
        chk(expb_q.size() == 0, "b_queue_drained", expb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog in case a bounded loop is ever miscounted.
    initial begin
        #900000;
        $display("FAIL watchdog: got %0d expected %0d", cyc, 0);
        $fatal(1, "watchdog expired");
    end

endmodule
